// File: rtl/mc_if.sv
// Control bundle between the multi-cycle controller and the MIPS-lite datapath.
// The controller uses the master modport, the datapath side uses slave.
interface mc_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  op, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
               pcsource, illegal_op, instr_done
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
               pcsource, illegal_op, instr_done
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the MIPS-lite datapath: sequences one shared ALU
// and one unified memory over 3-5 cycles per instruction, stalling on mem_ready.
//
// state       | meaning
// ------------+------------------------------------------------------------
// FETCH  (0)  | read instruction at PC, PC+4 -> PC and IR load on mem_ready
// DECODE (1)  | latch opcode, precompute branch target into ALUOut
// MEMADR (2)  | rs + imm -> ALUOut (lw/sw effective address)
// MEMRD  (3)  | data read at ALUOut, wait for mem_ready
// MEMWB  (4)  | MDR -> rt, lw done
// MEMWR  (5)  | data write at ALUOut, done on mem_ready
// EXEC   (6)  | rs funct rt
// RWB    (7)  | ALUOut -> rd, R-format done
// BRANCH (8)  | rs - rt, PC <= target if zero, beq done
// IEXEC  (9)  | rs nor imm
// IWB    (10) | ALUOut -> rt, nori done
// 11..15      | unused, return to FETCH with all outputs low
module mc_control #(
    parameter int STATE_W       = 4,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    mc_if.master               bus,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_RWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_IEXEC  = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_IWB    = STATE_W'(10);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_NORI = 6'b001101;

    logic [STATE_W-1:0] state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic               mem_ok;

    assign mem_ok  = USE_MEM_READY ? bus.mem_ready : 1'b1;
    assign state_o = state_q;

    // Next state and opcode capture; op is only looked at in DECODE.
    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = bus.op;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_NORI:      state_d = S_IEXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control outputs decoded from the current state; everything defaults low.
    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regdst      = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.aluop       = 2'b00;
        bus.pcsource    = 2'b00;
        bus.illegal_op  = 1'b0;
        bus.instr_done  = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = 2'b01;
                bus.irwrite = mem_ok;
                bus.pcwrite = mem_ok;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW, OP_R, OP_BEQ, OP_NORI: ;
                    default: begin
                        bus.illegal_op = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.regwrite   = 1'b1;
                bus.memtoreg   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.memwrite   = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = mem_ok;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_RWB: begin
                bus.regwrite   = 1'b1;
                bus.regdst     = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca     = 1'b1;
                bus.aluop       = 2'b01;
                bus.pcwritecond = 1'b1;
                bus.pcsource    = 2'b01;
                bus.instr_done  = 1'b1;
            end
            S_IEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b11;
            end
            S_IWB: begin
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // State and latched opcode; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: each driven cycle pushes the expected
// state and output vector onto a scoreboard, popped on the falling edge.
module tb_mc_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_NORI = 6'b001101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] v;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] state_o;
    logic [17:0] obs_vec;
    mc_if bus_if ();

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    mc_control #(.STATE_W(4), .USE_MEM_READY(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_vec = {bus_if.pcwrite, bus_if.pcwritecond, bus_if.iord,
                      bus_if.memread, bus_if.memwrite, bus_if.irwrite,
                      bus_if.memtoreg, bus_if.regdst, bus_if.regwrite,
                      bus_if.alusrca, bus_if.alusrcb, bus_if.aluop,
                      bus_if.pcsource, bus_if.illegal_op, bus_if.instr_done};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for a state, in the same bit order as obs_vec.
    function automatic logic [17:0] spec_out(input int st, input bit mr, input bit ill);
        logic pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, il, dn;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, il, dn} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; il = ill; dn = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; dn = 1; end
            5:  begin mwr = 1; io = 1; dn = mr; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; dn = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; dn = 1; end
            9:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
            10: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, il, dn};
    endfunction

    // Drive one cycle of inputs and record what the DUT should show in it.
    task automatic step(input int st, input bit mr, input logic [5:0] opv, input bit ill);
        exp_t e;
        bus_if.mem_ready = mr;
        bus_if.op        = opv;
        e.st = st[3:0];
        e.v  = spec_out(st, mr, ill);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] junk_op();
        return 6'($urandom);
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One complete instruction with the given fetch and memory wait cycles.
    task automatic do_instr(input logic [5:0] opc, input int fwait, input int mwait);
        for (int i = 0; i < fwait; i++) step(0, 1'b0, junk_op(), 1'b0);
        step(0, 1'b1, junk_op(), 1'b0);
        case (opc)
            OP_LW, OP_SW, OP_R, OP_BEQ, OP_NORI: step(1, rnd_bit(), opc, 1'b0);
            default:                             step(1, rnd_bit(), opc, 1'b1);
        endcase
        case (opc)
            OP_LW: begin
                step(2, rnd_bit(), junk_op(), 1'b0);
                for (int i = 0; i < mwait; i++) step(3, 1'b0, junk_op(), 1'b0);
                step(3, 1'b1, junk_op(), 1'b0);
                step(4, rnd_bit(), junk_op(), 1'b0);
            end
            OP_SW: begin
                step(2, rnd_bit(), junk_op(), 1'b0);
                for (int i = 0; i < mwait; i++) step(5, 1'b0, junk_op(), 1'b0);
                step(5, 1'b1, junk_op(), 1'b0);
            end
            OP_R: begin
                step(6, rnd_bit(), junk_op(), 1'b0);
                step(7, rnd_bit(), junk_op(), 1'b0);
            end
            OP_BEQ:  step(8, rnd_bit(), junk_op(), 1'b0);
            OP_NORI: begin
                step(9, rnd_bit(), junk_op(), 1'b0);
                step(10, rnd_bit(), junk_op(), 1'b0);
            end
            default: ;
        endcase
    endtask

    // Scoreboard consumer: compare each cycle away from the rising edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq($sformatf("state_exp%0d", e.st), {28'd0, state_o}, {28'd0, e.st});
            check_eq($sformatf("outs_s%0d", e.st), {14'd0, obs_vec}, {14'd0, e.v});
        end
    end

    initial begin
        logic [5:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ; ops[4] = OP_NORI;

        reset_n          = 1'b1;
        bus_if.op        = 6'd0;
        bus_if.mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_state", {28'd0, state_o}, 32'd0);
        check_eq("rst_memread", {31'd0, bus_if.memread}, 32'd1);
        check_eq("rst_regwrite", {31'd0, bus_if.regwrite}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // lw, no waits: 0,1,2,3,4
        do_instr(OP_LW, 0, 0);
        // sw with three wait cycles in MEMWR
        do_instr(OP_SW, 0, 3);
        // beq
        do_instr(OP_BEQ, 0, 0);
        // R then nori back to back
        do_instr(OP_R, 0, 0);
        do_instr(OP_NORI, 0, 0);
        // illegal opcode
        do_instr(OP_BAD, 0, 0);
        // fetch and memory stalls on lw
        do_instr(OP_LW, 2, 2);
        // unused-but-plausible opcode also illegal
        do_instr(6'b000010, 1, 0);
        // random mix
        for (int k = 0; k < 20; k++)
            do_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset while sitting in MEMWR with memwrite high.
        step(0, 1'b1, junk_op(), 1'b0);
        step(1, 1'b1, OP_SW, 1'b0);
        step(2, 1'b1, junk_op(), 1'b0);
        step(5, 1'b0, junk_op(), 1'b0);
        check_eq("pre_rst_state", {28'd0, state_o}, 32'd5);
        check_eq("pre_rst_memwrite", {31'd0, bus_if.memwrite}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_memwrite", {31'd0, bus_if.memwrite}, 32'd0);
        check_eq("mid_rst_state", {28'd0, state_o}, 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        check_eq("post_rst_state", {28'd0, state_o}, 32'd0);
        check_eq("post_rst_memread", {31'd0, bus_if.memread}, 32'd1);
        @(posedge clk);
        #1;
        do_instr(OP_BEQ, 0, 0);

        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
